// File: rtl/piece_sequencer.sv
// -----------------------------------------------------------------------------
// piece_sequencer
//
// Owns the active falling piece (origin, type, rotation) and turns player
// button pulses plus a gravity tick into moves. Each move is gated by the
// board store's combinational enables. Also runs the lock -> refresh ->
// refresh_done handshake with the store and forwards bomb requests.
//
// Optional feature: define HARD_DROP_EN to make btn_down start a hard drop.
// While the drop runs, y steps every cycle until edrop falls, then the piece
// locks. Without the macro, btn_down is a single soft step, exactly like a
// gravity tick.
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   start             begin game (accepted in IDLE only)
//   btn_l/r/rot/down  player move requests, 1-cycle pulses
//   btn_boom          bomb request, 1-cycle pulse
//   el, er, eu, edrop move enables from the board store for the current piece
//   overflow          piece occupies row <= 2 (checked at lock)
//   refresh_done      store finished merge/line-clear (1-cycle pulse)
//   x, y              piece origin, modulo-32
//   piece_type        current piece type 1..7 ("type" is a reserved word)
//   dir               rotation 0..3
//   next_type         preview of the following type (LFSR state)
//   refresh           1-cycle merge request
//   boom              1-cycle bomb request
//   game_over         sticky end-of-game flag
//   busy              high while in LOCK or CLEAR
// -----------------------------------------------------------------------------
module piece_sequencer #(
    parameter int TICK_DIV = 50_000_000,
    parameter int SPAWN_X  = 3,
    parameter int SPAWN_Y  = 0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_rot,
    input  logic       btn_down,
    input  logic       btn_boom,
    input  logic       el,
    input  logic       er,
    input  logic       eu,
    input  logic       edrop,
    input  logic       overflow,
    input  logic       refresh_done,
    output logic [4:0] x,
    output logic [4:0] y,
    output logic [2:0] piece_type,
    output logic [1:0] dir,
    output logic [2:0] next_type,
    output logic       refresh,
    output logic       boom,
    output logic       game_over,
    output logic       busy
);

    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
    localparam logic [4:0]    X0        = 5'(SPAWN_X);
    localparam logic [4:0]    Y0        = 5'(SPAWN_Y);
    // The seed 3'b001 is the type shown at reset; the preview holds one step on.
    localparam logic [2:0]    TYPE0     = 3'b001;
    localparam logic [2:0]    NEXT0     = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPAWN,
        S_FALL,
        S_LOCK,
        S_CLEAR,
        S_OVER
    } state_t;

    state_t        state, state_d;
    logic [4:0]    x_d, y_d;
    logic [2:0]    type_d, next_d;
    logic [1:0]    dir_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          pend, pend_d;
    logic          refresh_d, boom_d, busy_d, over_d;
    logic          tick, step_req;
`ifdef HARD_DROP_EN
    logic          drop, drop_d;
`endif

    // Galois LFSR for x^3 + x^2 + 1: 1,2,4,5,7,3,6 then repeats; never 0.
    function automatic logic [2:0] lfsr_step(input logic [2:0] q);
        return q[2] ? ({q[1:0], 1'b0} ^ 3'b101) : {q[1:0], 1'b0};
    endfunction

    assign tick     = (cnt == TICK_LAST);
    // A tick that lost to a higher-priority move stays pending for one slot.
    assign step_req = btn_down || tick || pend;

    // State register (also holds the piece datapath and registered outputs).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            x          <= X0;
            y          <= Y0;
            piece_type <= TYPE0;
            dir        <= 2'd0;
            next_type  <= NEXT0;
            cnt        <= '0;
            pend       <= 1'b0;
            refresh    <= 1'b0;
            boom       <= 1'b0;
            busy       <= 1'b0;
            game_over  <= 1'b0;
`ifdef HARD_DROP_EN
            drop       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed by the combinational processes.
            state      <= state_d;
            x          <= x_d;
            y          <= y_d;
            piece_type <= type_d;
            dir        <= dir_d;
            next_type  <= next_d;
            cnt        <= cnt_d;
            pend       <= pend_d;
            refresh    <= refresh_d;
            boom       <= boom_d;
            busy       <= busy_d;
            game_over  <= over_d;
`ifdef HARD_DROP_EN
            drop       <= drop_d;
`endif
        end
    end

    // Next-state and piece datapath.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case leaves a variable unassigned (no latches).
        state_d = state;
        x_d     = x;
        y_d     = y;
        type_d  = piece_type;
        dir_d   = dir;
        next_d  = next_type;
        cnt_d   = '0;
        pend_d  = 1'b0;
`ifdef HARD_DROP_EN
        drop_d  = 1'b0;
`endif

        unique case (state)
            S_IDLE: begin
                if (start) state_d = S_SPAWN;
            end

            S_SPAWN: begin
                type_d  = next_type;
                next_d  = lfsr_step(next_type);
                dir_d   = 2'd0;
                x_d     = X0;
                y_d     = Y0;
                state_d = S_FALL;
            end

            S_FALL: begin
                cnt_d  = tick ? '0 : cnt + CW'(1);
                pend_d = pend || tick;
`ifdef HARD_DROP_EN
                drop_d = drop;
                if (drop) begin
                    if (edrop) begin
                        y_d = y + 5'd1;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = S_LOCK;
                    end
                end else
`endif
                if (btn_rot && eu) begin
                    dir_d = dir + 2'd1;
                end else if (btn_l && el) begin
                    x_d = x - 5'd1;
                end else if (btn_r && er) begin
                    x_d = x + 5'd1;
                end else if (step_req) begin
                    pend_d = 1'b0;
                    if (edrop) begin
                        y_d   = y + 5'd1;
                        cnt_d = '0;
`ifdef HARD_DROP_EN
                        drop_d = btn_down;
`endif
                    end else begin
                        state_d = S_LOCK;
                    end
                end
            end

            S_LOCK: begin
                state_d = overflow ? S_OVER : S_CLEAR;
            end

            S_CLEAR: begin
                if (refresh_done) state_d = S_SPAWN;
            end

            S_OVER: begin
                state_d = S_OVER;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode; results are registered in the state register process.
    always_comb begin
        refresh_d = (state == S_LOCK) && !overflow;
`ifdef HARD_DROP_EN
        boom_d    = (state == S_FALL) && btn_boom && !drop;
`else
        boom_d    = (state == S_FALL) && btn_boom;
`endif
        busy_d    = (state_d == S_LOCK) || (state_d == S_CLEAR);
        over_d    = (state_d == S_OVER);
    end

endmodule

// File: tb/tb_piece_sequencer.sv
// -----------------------------------------------------------------------------
// tb_piece_sequencer
//
// Directed, self-checking bench for piece_sequencer with TICK_DIV = 4.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, i.e. they show the result of the edge just taken. Cycle labels Fn
// count cycles spent in FALL since the first spawn.
// -----------------------------------------------------------------------------
module tb_piece_sequencer;

    logic       clk;
    logic       rstn;
    logic       start, btn_l, btn_r, btn_rot, btn_down, btn_boom;
    logic       el, er, eu, edrop, overflow, refresh_done;
    logic [4:0] x, y;
    logic [2:0] piece_type, next_type;
    logic [1:0] dir;
    logic       refresh, boom, game_over, busy;

    int n_checks = 0;
    int n_fail   = 0;

    piece_sequencer #(
        .TICK_DIV(4),
        .SPAWN_X (3),
        .SPAWN_Y (0)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .btn_l       (btn_l),
        .btn_r       (btn_r),
        .btn_rot     (btn_rot),
        .btn_down    (btn_down),
        .btn_boom    (btn_boom),
        .el          (el),
        .er          (er),
        .eu          (eu),
        .edrop       (edrop),
        .overflow    (overflow),
        .refresh_done(refresh_done),
        .x           (x),
        .y           (y),
        .piece_type  (piece_type),
        .dir         (dir),
        .next_type   (next_type),
        .refresh     (refresh),
        .boom        (boom),
        .game_over   (game_over),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Types spawned after the first two (2 then 4), and the matching previews.
    logic [2:0] exp_type [6] = '{3'd5, 3'd7, 3'd3, 3'd6, 3'd1, 3'd2};
    logic [2:0] exp_next [6] = '{3'd7, 3'd3, 3'd6, 3'd1, 3'd2, 3'd4};
    logic [7:0] seen;

    initial begin
        rstn = 1'b0; start = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_rot = 1'b0;
        btn_down = 1'b0; btn_boom = 1'b0; el = 1'b0; er = 1'b0; eu = 1'b0;
        edrop = 1'b0; overflow = 1'b0; refresh_done = 1'b0;

        // ---- reset values ----
        cyc(); cyc();
        check("rst_x", x, 3);
        check("rst_y", y, 0);
        check("rst_type", piece_type, 1);
        check("rst_dir", dir, 0);
        check("rst_next", next_type, 2);
        check("rst_refresh", refresh, 0);
        check("rst_boom", boom, 0);
        check("rst_over", game_over, 0);
        check("rst_busy", busy, 0);

        // ---- start -> SPAWN -> FALL ----
        rstn = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;          // SPAWN
        check("spawn_busy", busy, 0);
        cyc();                                      // F0
        check("spawn_type", piece_type, 2);
        check("spawn_next", next_type, 4);
        check("spawn_x", x, 3);
        check("spawn_y", y, 0);
        check("spawn_dir", dir, 0);

        // ---- simultaneous / refused requests ----
        el = 1'b1; er = 1'b1; eu = 1'b1; edrop = 1'b1;
        btn_rot = 1'b1; btn_l = 1'b1; cyc(); btn_rot = 1'b0; btn_l = 1'b0;  // F1
        check("rot_wins_dir", dir, 1);
        check("rot_wins_x", x, 3);
        btn_r = 1'b1; er = 1'b0; cyc(); btn_r = 1'b0; er = 1'b1;           // F2
        check("r_refused_x", x, 3);
        cyc();                                      // F3 (tick cycle)
        check("r_no_replay_x", x, 3);
        check("pre_tick_y", y, 0);

        // ---- gravity every 4 cycles; stray refresh_done ignored ----
        refresh_done = 1'b1; cyc(); refresh_done = 0;                      // F4
        check("tick1_y", y, 1);
        check("stray_done_busy", busy, 0);
        cyc(); cyc(); cyc();                        // F7
        check("tick2_early_y", y, 1);
        cyc();                                      // F8
        check("tick2_y", y, 2);

        // ---- tick loses to a move, serviced next cycle ----
        cyc(); cyc(); cyc();                        // F11 (tick cycle)
        btn_l = 1'b1; cyc(); btn_l = 1'b0;          // F12
        check("pend_move_x", x, 2);
        check("pend_move_y", y, 2);
        cyc();                                      // F13
        check("pend_served_y", y, 3);

        // ---- bomb in FALL ----
        btn_boom = 1'b1; cyc(); btn_boom = 1'b0;    // F14
        check("boom_pulse", boom, 1);
        cyc();                                      // F15
        check("boom_one_cycle", boom, 0);

        // ---- back-to-back left moves wrap x below zero ----
        btn_l = 1'b1;
        cyc(); check("left_x1", x, 1);              // F16
        cyc(); check("left_x0", x, 0);              // F17
        cyc(); check("left_wrap_x", x, 31);         // F18
        check("left_wrap_y", y, 3);
        btn_l = 1'b0;
        cyc();                                      // F19
        check("pend_twice_y", y, 4);
        btn_r = 1'b1; cyc(); btn_r = 1'b0;          // F20
        check("right_wrap_x", x, 0);

        // ---- btn_down: soft step or hard drop, then lock via edrop=0 ----
`ifdef HARD_DROP_EN
        btn_down = 1'b1; cyc(); btn_down = 1'b0;    // F21
        check("drop_first_y", y, 5);
        cyc(); btn_l = 1'b1; cyc(); btn_l = 1'b0; cyc(); cyc();            // F25
        check("drop_total_y", y, 9);
        check("drop_ignores_l", x, 0);
        edrop = 1'b0;
        check("drop_busy", busy, 0);
        cyc();                                      // LOCK
`else
        btn_down = 1'b1; cyc(); btn_down = 1'b0;    // F21
        check("soft_step_y", y, 5);
        cyc();                                      // F22
        check("soft_once_y", y, 5);
        edrop = 1'b0;
        cyc(); cyc();                               // F24 (tick with edrop=0)
        check("prelock_busy", busy, 0);
        cyc();                                      // LOCK
`endif
        check("lock_busy", busy, 1);
        check("lock_refresh", refresh, 0);
        cyc();                                      // CLEAR #1
        check("refresh_pulse", refresh, 1);
        check("clear_busy", busy, 1);
        cyc();                                      // CLEAR #2
        check("refresh_single", refresh, 0);
        check("clear_busy2", busy, 1);
        btn_boom = 1'b1; btn_l = 1'b1; cyc(); btn_boom = 1'b0; btn_l = 1'b0;
        check("clear_no_boom", boom, 0);
        check("clear_no_move", x, 0);
        check("clear_busy3", busy, 1);
        refresh_done = 1'b1; cyc(); refresh_done = 1'b0;                   // SPAWN
        check("done_busy", busy, 0);
        cyc();                                      // FALL
        check("spawn2_type", piece_type, 4);
        check("spawn2_next", next_type, 5);
        check("spawn2_x", x, 3);
        check("spawn2_y", y, 0);

        // ---- LFSR: 7 consecutive spawns cover 1..7 ----
        seen = 8'h00;
        seen[piece_type] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            btn_down = 1'b1; edrop = 1'b0; cyc(); btn_down = 1'b0;         // LOCK
            cyc();                                                          // CLEAR
            refresh_done = 1'b1; cyc(); refresh_done = 1'b0;               // SPAWN
            cyc();                                                          // FALL
            check($sformatf("lfsr_type_%0d", i), piece_type, exp_type[i]);
            check($sformatf("lfsr_next_%0d", i), next_type, exp_next[i]);
            seen[piece_type] = 1'b1;
        end
        check("lfsr_cover", seen, 8'hFE);

        // ---- lock with overflow -> OVER, no refresh ----
        btn_down = 1'b1; overflow = 1'b1; cyc(); btn_down = 1'b0;          // LOCK
        check("ovf_lock_busy", busy, 1);
        cyc();                                      // OVER
        check("over_flag", game_over, 1);
        check("over_refresh", refresh, 0);
        check("over_busy", busy, 0);
        start = 1'b1; btn_l = 1'b1; btn_boom = 1'b1; btn_down = 1'b1;
        refresh_done = 1'b1; edrop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check($sformatf("over_hold_%0d", i), game_over, 1);
            check($sformatf("over_norefresh_%0d", i), refresh, 0);
            check($sformatf("over_noboom_%0d", i), boom, 0);
            check($sformatf("over_x_%0d", i), x, 3);
            check($sformatf("over_y_%0d", i), y, 0);
            check($sformatf("over_type_%0d", i), piece_type, 2);
        end
        start = 1'b0; btn_l = 1'b0; btn_boom = 1'b0; btn_down = 1'b0;
        refresh_done = 1'b0; edrop = 1'b0; overflow = 1'b0;

        // ---- asynchronous reset out of OVER ----
        rstn = 1'b0; #1;
        check("rst_over_flag", game_over, 0);
        check("rst_over_type", piece_type, 1);
        check("rst_over_next", next_type, 2);
        check("rst_over_busy", busy, 0);

        // ---- asynchronous reset mid-CLEAR ----
        cyc(); rstn = 1'b1;
        start = 1'b1; cyc(); start = 1'b0;          // SPAWN
        cyc();                                      // FALL
        btn_down = 1'b1; cyc(); btn_down = 1'b0;    // LOCK
        cyc();                                      // CLEAR
        check("mid_clear_refresh", refresh, 1);
        check("mid_clear_busy", busy, 1);
        rstn = 1'b0; #1;
        check("rst_clear_refresh", refresh, 0);
        check("rst_clear_busy", busy, 0);
        check("rst_clear_type", piece_type, 1);
        cyc(); rstn = 1'b1;
        refresh_done = 1'b1; cyc(); refresh_done = 1'b0;
        cyc();
        check("idle_ignores_done_busy", busy, 0);
        check("idle_ignores_done_type", piece_type, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piece_sequencer.md
# piece_sequencer

Game sequencer for the falling-block board store. It owns the active piece's registers (`x`, `y`, `type`, `dir`) and draws new types from an LFSR. It turns player button pulses and a gravity tick into moves, gated by the board store's enables (`el`, `er`, `eu`, `edrop`). It runs the lock → `refresh` → `refresh_done` handshake and forwards bomb requests. It sits between the input debouncers and the board store; the display and score paths read the store directly.

## Interface
Parameters:
- `TICK_DIV`, default 50_000_000: clock cycles per gravity step (≥2).
- `SPAWN_X`, default 3: spawn column of the piece origin.
- `SPAWN_Y`, default 0: spawn row of the piece origin.

Ports (all button inputs are 1-cycle pulses, already synchronised):
- `clk`  in  1: clock. One clock domain; all outputs are registered on its rising edge.
- `rstn`  in  1: asynchronous active-low reset.
- `start`  in  1: begin game.
- `btn_l`, `btn_r`, `btn_rot`, `btn_down`, `btn_boom`  in  1 each: player requests.
- `el`, `er`, `eu`, `edrop`  in  1 each: combinational move enables from the board store for the current `x`/`y`/`type`/`dir`.
- `overflow`  in  1: piece occupies row ≤2.
- `refresh_done`  in  1: board merge/line-clear finished (1-cycle pulse).
- `x`, `y`  out  5: piece origin.
- `type`  out  3: piece type, 1..7.
- `dir`  out  2: rotation.
- `next_type`  out  3: preview of the following type.
- `refresh`  out  1: 1-cycle merge request.
- `boom`  out  1: 1-cycle bomb request.
- `game_over`  out  1: sticky end-of-game flag.
- `busy`  out  1: high in LOCK and CLEAR.

## Operation
States: IDLE, SPAWN, FALL, LOCK, CLEAR, OVER.

- **IDLE:** hold the spawn position. `start` → SPAWN.
- **SPAWN (1 cycle):**
  - `type` ← `next_type`; LFSR steps (`next_type` ← new LFSR value); `dir` ← 0; `x` ← SPAWN_X; `y` ← SPAWN_Y.
  - Tick counter cleared. → FALL.
- **FALL:** at most one action per cycle, in this priority order:
  1. `btn_rot` with `eu` → `dir` ← `dir`+1 (mod 4).
  2. `btn_l` with `el` → `x` ← `x`−1.
  3. `btn_r` with `er` → `x` ← `x`+1.
  4. `btn_down`, or the tick counter at TICK_DIV−1 → if `edrop`, `y` ← `y`+1 and the counter clears; otherwise → LOCK.
  - A request whose enable is low is dropped, not queued.
  - A lower-priority request in the same cycle as a higher one is dropped.
  - The tick counter free-runs in FALL. On a cycle where the tick fires but a higher-priority move wins, the tick is held pending and serviced on the next cycle.
  - `btn_boom` → `boom` pulses one cycle, in addition to any move. The store decrements its own bomb count.
- **LOCK (1 cycle):** if `overflow` → OVER with no refresh. Otherwise `refresh` pulses → CLEAR.
- **CLEAR:** ignore all buttons; wait for `refresh_done` → SPAWN.
- **OVER:** `game_over` = 1 and every input is ignored. Only `rstn` leaves this state.

Arithmetic and width rules:
- `x`/`y` use 5-bit modulo-32 arithmetic. `x` = 0 minus 1 gives 31; this is intended, because the store adds cell offsets modulo 32.
- LFSR: 3-bit, polynomial x³+x²+1, seed 3'b001, period 7, never 0. `type` is therefore always 1..7.
- Tick counter width is $clog2(TICK_DIV).

## Timing
- **Reset values:**
  - `x` = SPAWN_X, `y` = SPAWN_Y, `type` = 1, `dir` = 0, `next_type` = 2.
  - `refresh`, `boom`, `game_over`, `busy` = 0.
  - State = IDLE; tick counter = 0.
- Moves take effect on the edge after the request. Enables are expected to be valid in the following cycle, so back-to-back moves in consecutive cycles are legal.
- From the cycle `edrop`=0 is sampled with a step pending:
  - `refresh` is high exactly 2 cycles later (LOCK → FALL+1).
  - SPAWN follows the cycle after `refresh_done`.
- `refresh_done` arriving outside CLEAR is ignored.
- `rstn` asserted in any state, including mid-CLEAR, returns all outputs to their reset values immediately. A refresh already in flight in the store is not tracked.

## Configuration
- `HARD_DROP_EN` defined:
  - In FALL, `btn_down` starts a hard drop: `y` increments every cycle while `edrop`=1, then the block enters LOCK.
  - `btn_l`, `btn_r`, `btn_rot`, `btn_boom` and the tick are ignored during the drop.
- `HARD_DROP_EN` undefined: `btn_down` is a single soft step, identical to a gravity tick.

## Test plan
- **Reset then spawn:** `rstn` low then high, then `start` → after 2 cycles `type`=2, `next_type`=4, `x`=3, `y`=0, `dir`=0, state FALL.
- **Simultaneous and refused requests:** `btn_rot` and `btn_l` in the same cycle with `eu`=`el`=1 → only `dir`=1, `x` unchanged. Then `btn_r` with `er`=0 → `x` unchanged, and a later `btn_r` with `er`=1 does not replay it.
- **Gravity tick:** TICK_DIV=4 and no buttons → `y` increments every 4 cycles. With `edrop`=0 at a tick → `refresh` pulses once 2 cycles later, `busy`=1 until 1 cycle after `refresh_done`.
- **Game over:** lock with `overflow`=1 → `game_over`=1, `refresh` never asserts, and `start` and buttons are ignored until `rstn`.
- **LFSR and bomb:** 7 consecutive spawns → `type` sequence covers 1..7 exactly once. `btn_boom` in FALL → `boom`=1 for 1 cycle; in CLEAR → no pulse.
- **Hard drop:** with HARD_DROP_EN, `btn_down` and `edrop` high for 5 cycles → `y` +5, then LOCK. Without the macro → `y` +1 only.
